// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared widths, FSM states and saturation limits for the MFCC divider
package mfcc_pkg;

  localparam int DEF_DATA_W = 40;
  localparam int DEF_FRAC_W = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DEF_DATA_W-1:0] SAT_POS = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic [DEF_DATA_W-1:0] SAT_NEG = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

// File: rtl/udiv_iter.sv
// rtl/udiv_iter.sv - unsigned restoring divider, one quotient bit per cycle after start
module udiv_iter #(
  parameter int N  = 56,
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic [N-1:0]  quotient,
  output logic          done
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  dvd;
  logic [DW-1:0] dvs;
  logic [DW:0]   rem;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [DW+1:0] rem_sh;
  logic [DW+1:0] diff;
  logic          fits;

  // rem stays below dvs, so the top bit of rem_sh is zero and the borrow of diff is the compare
  assign rem_sh = {rem, dvd[N-1]};
  assign diff   = rem_sh - {2'b00, dvs};
  assign fits   = ~diff[DW+1];
  assign done   = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      dvd      <= dividend;
      dvs      <= divisor;
      rem      <= '0;
      quotient <= '0;
      cnt      <= CW'(N - 1);
      busy     <= 1'b1;
    end else if (busy) begin
      dvd      <= {dvd[N-2:0], 1'b0};
      rem      <= fits ? diff[DW:0] : rem_sh[DW:0];
      quotient <= {quotient[N-2:0], fits};
      cnt      <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mfcc_div.sv
// rtl/mfcc_div.sv - free-running signed fixed-point divider, result = x * 2^FRAC_W / y
module mfcc_div
  import mfcc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] MFCC_mean,
  output logic              res_valid
);

  localparam int N = DATA_W + FRAC_W;
  localparam logic [N-1:0] MAG_POS = {{(FRAC_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [N-1:0] MAG_NEG = MAG_POS + 1'b1;

  state_t            state;
  logic [DATA_W-1:0] ax;
  logic [DATA_W-1:0] ay;
  logic              sx;
  logic              sy;
  logic              x_zero;
  logic              y_zero;
  logic [N-1:0]      quotient;
  logic              core_done;
  logic [DATA_W-1:0] result;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(DATA_W-1) exactly
  assign ax = x[DATA_W-1] ? -x : x;
  assign ay = y[DATA_W-1] ? -y : y;

  udiv_iter #(
    .N  (N),
    .DW (DATA_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (state == LOAD),
    .dividend ({ax, {FRAC_W{1'b0}}}),
    .divisor  (ay),
    .quotient (quotient),
    .done     (core_done)
  );

  always_comb begin
    result = '0;
    if (y_zero) begin
      if (!x_zero) result = sx ? SAT_NEG : SAT_POS;
    end else if (sx ^ sy) begin
      result = (quotient > MAG_NEG) ? SAT_NEG : -quotient[DATA_W-1:0];
    end else begin
      result = (quotient > MAG_POS) ? SAT_POS : quotient[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      MFCC_mean <= '0;
      res_valid <= 1'b0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      x_zero    <= 1'b0;
      y_zero    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        LOAD: begin
          sx     <= x[DATA_W-1];
          sy     <= y[DATA_W-1];
          x_zero <= (x == '0);
          y_zero <= (y == '0);
          state  <= CALC;
        end
        CALC: if (core_done) state <= DONE;
        DONE: begin
          MFCC_mean <= result;
          res_valid <= 1'b1;
          state     <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_div.sv
// tb/tb_mfcc_div.sv - scoreboard bench for mfcc_div with an arithmetic reference model
module tb_mfcc_div;

  localparam int W    = 40;
  localparam int F    = 16;
  localparam int PER  = 58;
  localparam int NDIR = 12;
  localparam int NVEC = 42;

  typedef struct {
    logic [W-1:0] v;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [W-1:0] mean;
  logic         res_valid;

  mfcc_div #(.DATA_W(W), .FRAC_W(F)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .MFCC_mean (mean),
    .res_valid (res_valid)
  );

  always #5 clk = ~clk;

  int           cyc = 0;
  int           phase = 0;
  int           errors = 0;
  int           checks = 0;
  bit           rst_edge = 1'b0;
  logic [W-1:0] last_mean = '0;
  exp_t         sb[$];
  logic [W-1:0] dx[NDIR];
  logic [W-1:0] dy[NDIR];

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint xa, yb, q, maxp;
    logic [W-1:0] pos, neg;
    xa   = longint'($signed(a));
    yb   = longint'($signed(b));
    maxp = (longint'(1) << (W - 1)) - 1;
    pos  = maxp[W-1:0];
    neg  = pos + 1'b1;
    if (yb == 0) begin
      if (xa > 0) return pos;
      if (xa < 0) return neg;
      return '0;
    end
    q = (xa * 65536) / yb;
    if (q > maxp) return pos;
    if (q < -maxp - 1) return neg;
    return q[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: operands present at every LOAD edge produce a result 57 edges later
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      phase    = 0;
      rst_edge = 1'b1;
      sb.delete();
    end else begin
      rst_edge = 1'b0;
      if (phase == 0) sb.push_back('{v: ref_div(x, y), due: cyc + PER - 1});
      phase = (phase == PER - 1) ? 0 : phase + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_edge) begin
      chk("reset_mean", mean, '0);
      chk("reset_valid", {{(W-1){1'b0}}, res_valid}, '0);
      last_mean = '0;
    end else if (res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {{(W-1){1'b0}}, res_valid}, '0);
      end else begin
        e = sb.pop_front();
        chk("latency", W'(cyc), W'(e.due));
        chk("quotient", mean, e.v);
      end
      last_mean = mean;
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("missing_valid", {{(W-1){1'b0}}, res_valid}, {{(W-1){1'b0}}, 1'b1});
      end
      chk("hold", mean, last_mean);
    end
  end

  function automatic logic [W-1:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_y(input logic [W-1:0] xv);
    logic [W-1:0] m;
    case ($urandom_range(0, 3))
      0: m = rnd40();
      1: m = W'($urandom_range(1, 32'h3FFFF));
      2: m = '0;
      default: m = xv >> $urandom_range(0, 24);
    endcase
    if ($urandom_range(0, 1) == 1) m = -m;
    return m;
  endfunction

  initial begin
    int  vi;
    bit  rst_done;
    dx[0]  = 40'h00000A0000; dy[0]  = 40'h0000040000;
    dx[1]  = 40'hFFFFFD0000; dy[1]  = 40'h0000020000;
    dx[2]  = 40'h0000010000; dy[2]  = 40'h0000030000;
    dx[3]  = 40'hFFFFFF0000; dy[3]  = 40'h0000030000;
    dx[4]  = 40'h0000050000; dy[4]  = 40'h0000000000;
    dx[5]  = 40'hFFFFFB0000; dy[5]  = 40'h0000000000;
    dx[6]  = 40'h0000000000; dy[6]  = 40'h0000000000;
    dx[7]  = 40'h7FFFFFFFFF; dy[7]  = 40'h0000000001;
    dx[8]  = 40'h8000000000; dy[8]  = 40'h0000010000;
    dx[9]  = 40'h8000000000; dy[9]  = 40'hFFFFFFFFFF;
    dx[10] = 40'h8000000000; dy[10] = 40'h8000000000;
    dx[11] = 40'h0000000001; dy[11] = 40'h7FFFFFFFFF;

    vi       = 0;
    rst_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < (NVEC + 2) * PER && vi < NVEC; c++) begin
      // One mid-CALC reset after the directed vectors have completed
      if (!rst_done && vi == NDIR + 1 && phase == 20) begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        rst_done = 1'b1;
      end
      if (phase == 0) begin
        if (vi < NDIR) begin
          x = dx[vi];
          y = dy[vi];
        end else begin
          x = rnd40();
          if ($urandom_range(0, 3) == 0) x = x >>> $urandom_range(8, 30);
          y = rnd_y(x);
        end
        vi++;
      end else begin
        x = rnd40();
        y = rnd40();
      end
      @(negedge clk);
    end
    repeat (PER + 5) @(negedge clk);
    checks++;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      errors++;
      $display("FAIL drain: %0d results outstanding past due", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfcc_div.md
Name: mfcc_div

Overview:
- Signed fixed-point divider used in the MFCC normalisation path.
- One instance computes the frame-average, x / (frame count); a second computes the scaled value, (x - mean) / scale.
- Both operands and the result use the same signed fixed-point format, DATA_W bits with FRAC_W fraction bits; the result is registered.
- The unit is iterative and free-running. It samples both operands, computes one quotient bit per cycle, updates the output, then immediately samples again.

Parameters:
- DATA_W, 40, total width of x, y and quotient (two's complement).
- FRAC_W, 16, number of fraction bits in x, y and quotient.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- x, input, DATA_W, signed dividend.
- y, input, DATA_W, signed divisor.
- MFCC_mean, output, DATA_W, registered signed quotient.
- res_valid, output, 1, one-cycle strobe when MFCC_mean is updated; may be left unconnected.

Behaviour:
- Function: MFCC_mean = trunc_toward_zero(x * 2^FRAC_W / y), as two's-complement DATA_W bits.
- Magnitudes: compute |x| and |y| as DATA_W-bit unsigned values, so -2^(DATA_W-1) is handled exactly.
- Core division: unsigned restoring division of the N-bit dividend (|x| << FRAC_W) by |y|, where N = DATA_W + FRAC_W = 56.
- Result sign: negate the unsigned quotient when sign(x) XOR sign(y) = 1.
- Saturation: if the unsigned quotient exceeds 2^(DATA_W-1)-1, clamp to 0x7FFFFFFFFF for a positive result and 0x8000000000 for a negative result. A negative magnitude of exactly 2^(DATA_W-1) is not clamped.
- Divide by zero (y = 0): result is 0x7FFFFFFFFF if x > 0, 0x8000000000 if x < 0, 0 if x = 0.
- State machine, LOAD -> CALC -> DONE -> LOAD:
  - LOAD, 1 cycle: capture x and y, signs and magnitudes; clear remainder and quotient; bit counter = N-1.
  - CALC, N cycles: shift in the next dividend bit, compare with |y|, subtract if remainder >= |y|, shift the quotient bit in, decrement the counter. Leave CALC after bit 0.
  - DONE, 1 cycle: apply sign, saturation and divide-by-zero rules; register MFCC_mean; pulse res_valid = 1.
- Latency: operands sampled in LOAD appear on MFCC_mean N+2 = 58 cycles later; results repeat every 58 cycles.
- Operand changes during CALC or DONE do not affect the in-flight result. They are picked up at the next LOAD.
- MFCC_mean holds its last value between DONE cycles.
- Reset (reset = 0 at a clk edge), including mid-operation: state = LOAD, MFCC_mean = 0, res_valid = 0, remainder, quotient and counter = 0. The in-flight result is discarded. The first post-reset LOAD happens on the first edge with reset = 1.

Decomposition:
- Shared package mfcc_pkg holds:
  - DATA_W and FRAC_W defaults;
  - the state enum {LOAD, CALC, DONE};
  - the saturation constants SAT_POS and SAT_NEG.
- One natural sub-module: udiv_iter, an unsigned N-bit by DATA_W-bit restoring core with a start/done handshake. mfcc_div wraps it with sign handling, saturation and output registering.

Test Plan:
- Basic divide: x = 0x00000A0000 (10.0), y = 0x0000040000 (4.0) -> MFCC_mean = 0x0000028000 (2.5) and res_valid = 1, exactly 58 cycles after LOAD.
- Signed, negative dividend: x = 0xFFFFFD0000 (-3.0), y = 0x0000020000 (2.0) -> 0xFFFFFE8000 (-1.5).
- Truncation toward zero:
  - x = 0x0000010000, y = 0x0000030000 -> 0x0000005555.
  - x = 0xFFFFFF0000, same y -> 0xFFFFFFAAAB.
- Divide by zero, y = 0:
  - x = 0x0000050000 -> 0x7FFFFFFFFF.
  - x = 0xFFFFFB0000 -> 0x8000000000.
  - x = 0 -> 0.
- Overflow: x = 0x7FFFFFFFFF, y = 0x0000000001 -> 0x7FFFFFFFFF; x = 0x8000000000, y = 0x0000010000 -> 0x8000000000.
- Operand change and reset:
  - Change x at cycle 10 of CALC -> that result still uses the old operands; the new operands appear one period later.
  - reset = 0 mid-CALC -> next edge gives MFCC_mean = 0 and state LOAD; a full 58-cycle latency applies after reset is released.
